// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
// Build option DMEM_ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
package dmem_arb_pkg;

    localparam int DM_ADDRESS_DEF = 9;
    localparam int DATA_W_DEF     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic port_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant logic with last-grant pointer.
// DMEM_ARB_FIXED_PRIO_EN: port 0 always wins ties and the pointer is ignored.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    port_t last;
    port_t win;

    always_comb begin
        win = 1'b0;
        if (req == 2'b10) begin
            win = 1'b1;
        end else if (req == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ~last;
`endif
        end
    end

    assign grant[0] = en && req[0] && !win;
    assign grant[1] = en && req[1] && win;

    // Reset to port 1 so port 0 takes the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (|grant) begin
            last <= win;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one data memory: IDLE -> ACCESS -> RESP.
// Build option DMEM_ARB_FIXED_PRIO_EN selects fixed priority (see rr_arbiter2).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = DM_ADDRESS_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [DM_ADDRESS-1:0] req0_addr,
    input  logic [DATA_W-1:0]     req0_wdata,
    input  logic [2:0]            req0_funct3,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [DM_ADDRESS-1:0] req1_addr,
    input  logic [DATA_W-1:0]     req1_wdata,
    input  logic [2:0]            req1_funct3,
    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd
);

    state_t                state;
    logic                  we_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [2:0]            f3_q;
    port_t                 win_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [1:0]            grant;
    logic                  arb_en;

    // Ready is forced low while reset is held.
    assign arb_en = (state == IDLE) && !reset;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   ({req1_valid, req0_valid}),
        .grant (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            win_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        state   <= ACCESS;
                        win_q   <= grant[1];
                        we_q    <= grant[1] ? req1_we     : req0_we;
                        addr_q  <= grant[1] ? req1_addr   : req0_addr;
                        wdata_q <= grant[1] ? req1_wdata  : req0_wdata;
                        f3_q    <= grant[1] ? req1_funct3 : req0_funct3;
                    end
                end
                ACCESS: begin
                    rdata_q <= we_q ? '0 : mem_rd;
                    state   <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign mem_read   = (state == ACCESS) && !we_q;
    assign mem_write  = (state == ACCESS) && we_q;
    assign mem_a      = addr_q;
    assign mem_wd     = wdata_q;
    assign mem_funct3 = f3_q;

    assign rsp0_valid = (state == RESP) && !win_q;
    assign rsp1_valid = (state == RESP) && win_q;
    assign rsp_rdata  = (state == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word memory.
// Honors DMEM_ARB_FIXED_PRIO_EN for the tie-break expectations.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 0, req0_we = 0;
    logic        req1_valid = 0, req1_we = 0;
    logic [8:0]  req0_addr = 0, req1_addr = 0;
    logic [31:0] req0_wdata = 0, req1_wdata = 0;
    logic [2:0]  req0_funct3 = 0, req1_funct3 = 0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_rdata;
    logic        mem_read, mem_write;
    logic [8:0]  mem_a;
    logic [31:0] mem_wd;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rd;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem [0:127];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_we     (req0_we),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_funct3 (req0_funct3),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_we     (req1_we),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_funct3 (req1_funct3),
        .rsp0_valid  (rsp0_valid),
        .rsp1_valid  (rsp1_valid),
        .rsp_rdata   (rsp_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_a       (mem_a),
        .mem_wd      (mem_wd),
        .mem_funct3  (mem_funct3),
        .mem_rd      (mem_rd)
    );

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        if (mem_write) mem[mem_a[8:2]] <= mem_wd;
    end

    assign mem_rd = mem[mem_a[8:2]];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid,
             mem_read, mem_write} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                      mem_read, mem_write});
        end
        n_checks++;
        if ({mem_a, mem_wd, mem_funct3, rsp_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got a=%h wd=%h f3=%h rd=%h want 0",
                     mem_a, mem_wd, mem_funct3, rsp_rdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_store();
        req0_valid = 1; req0_we = 1; req0_addr = 9'h010;
        req0_wdata = 32'hDEADBEEF; req0_funct3 = 3'b010;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL store_ready: got r0=%b r1=%b want 1 0",
                     req0_ready, req1_ready);
        end
        tick();
        req0_valid = 0; req0_wdata = 0; req0_addr = 0;
        #1;
        n_checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL store_access: got w=%b r=%b rdy=%b want 1 0 0",
                     mem_write, mem_read, req0_ready);
        end
        n_checks++;
        if (mem_a !== 9'h010 || mem_wd !== 32'hDEADBEEF || mem_funct3 !== 3'b010) begin
            n_fail++;
            $display("FAIL store_bus: got a=%h wd=%h f3=%b want 010 deadbeef 010",
                     mem_a, mem_wd, mem_funct3);
        end
        tick();
        n_checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 ||
            rsp_rdata !== 32'h0 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL store_rsp: got v0=%b v1=%b rd=%h w=%b want 1 0 0 0",
                     rsp0_valid, rsp1_valid, rsp_rdata, mem_write);
        end
        tick();
        n_checks++;
        if (rsp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_rsp_pulse: got v0=%b want 0", rsp0_valid);
        end
    endtask

    task automatic test_load();
        req1_valid = 1; req1_we = 0; req1_addr = 9'h010; req1_funct3 = 3'b010;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ready: got r0=%b r1=%b want 0 1",
                     req0_ready, req1_ready);
        end
        tick();
        req1_valid = 0;
        #1;
        n_checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_a !== 9'h010) begin
            n_fail++;
            $display("FAIL load_access: got r=%b w=%b a=%h want 1 0 010",
                     mem_read, mem_write, mem_a);
        end
        tick();
        n_checks++;
        if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 ||
            rsp_rdata !== 32'hDEADBEEF || mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL load_rsp: got v1=%b v0=%b rd=%h r=%b want 1 0 deadbeef 0",
                     rsp1_valid, rsp0_valid, rsp_rdata, mem_read);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic exp0, exp1, exp_v0, exp_v1;
        logic w;
        reset = 1;
        tick();
        req0_valid = 1; req0_we = 0; req0_addr = 9'h020;
        req1_valid = 1; req1_we = 0; req1_addr = 9'h024;
        reset = 0;
        for (int i = 0; i < 12; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = ((i / 3) % 2) == 1;
`endif
            exp0 = (i % 3 == 0) && !w;
            exp1 = (i % 3 == 0) && w;
            exp_v0 = (i % 3 == 2) && !w;
            exp_v1 = (i % 3 == 2) && w;
            #1;
            n_checks++;
            if (req0_ready !== exp0 || req1_ready !== exp1) begin
                n_fail++;
                $display("FAIL rr_ready[%0d]: got %b%b want %b%b",
                         i, req0_ready, req1_ready, exp0, exp1);
            end
            n_checks++;
            if (rsp0_valid !== exp_v0 || rsp1_valid !== exp_v1) begin
                n_fail++;
                $display("FAIL rr_rsp[%0d]: got %b%b want %b%b",
                         i, rsp0_valid, rsp1_valid, exp_v0, exp_v1);
            end
            tick();
        end
        req0_valid = 0;
        req1_valid = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        req0_valid = 1; req0_we = 0; req0_addr = 9'h010;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_grant: got r0=%b want 1", req0_ready);
        end
        tick();
        req0_valid = 0;
        #1;
        n_checks++;
        if (mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_access: got r=%b want 1", mem_read);
        end
        reset = 1;
        #1;
        n_checks++;
        if (mem_read !== 1'b0 || rsp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_drop: got r=%b v0=%b want 0 0",
                     mem_read, rsp0_valid);
        end
        tick();
        n_checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_norsp: got v0=%b v1=%b want 0 0",
                     rsp0_valid, rsp1_valid);
        end
        reset = 0;
        req0_valid = 1; req1_valid = 1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_regrant: got r0=%b r1=%b want 1 0",
                     req0_ready, req1_ready);
        end
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
        tick();
    endtask

    task automatic test_single_port();
        logic [8:0] a;
        for (int k = 0; k < 4; k++) begin
            a = (k == 3) ? 9'h1FF : 9'(9'h040 + 4 * k);
            req1_valid = 1; req1_we = 1; req1_addr = a;
            req1_wdata = 32'h1000 + k; req1_funct3 = 3'b111;
            #1;
            n_checks++;
            if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL single_grant[%0d]: got r0=%b r1=%b want 0 1",
                         k, req0_ready, req1_ready);
            end
            tick();
            req1_valid = 0;
            #1;
            n_checks++;
            if (mem_a !== a || mem_write !== 1'b1 || req0_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL single_access[%0d]: got a=%h w=%b r0=%b want %h 1 0",
                         k, mem_a, mem_write, req0_ready, a);
            end
            tick();
            n_checks++;
            if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL single_rsp[%0d]: got v1=%b v0=%b r0=%b want 1 0 0",
                         k, rsp1_valid, rsp0_valid, req0_ready);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_round_robin();
        test_reset_mid();
        test_single_port();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
